// File: rtl/img_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// img_load_ctrl_if
// Groups the image-loader handshake and SRAM bank bus so that the loader,
// its upstream source and the core's bank arbiter share one bundle.
//
//   i_start      request to begin a load (source -> loader)
//   i_in_valid   input byte valid        (source -> loader)
//   i_in_data    input byte              (source -> loader)
//   o_in_ready   loader accepts a byte   (loader -> source)
//   o_bank_cen   per-bank chip enable, active-low  (loader -> banks)
//   o_bank_wen   per-bank write enable, active-low (loader -> banks)
//   o_bank_addr  shared bank address     (loader -> banks)
//   o_bank_d     shared bank write data  (loader -> banks)
//   o_busy       load in progress; core keeps off the banks
//   o_done       one-cycle pulse once the final write has been presented
//
// master: the side feeding the loader (stream source / testbench)
// slave : the loader itself
// ---------------------------------------------------------------------------
interface img_load_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
);
    logic              i_start;
    logic              i_in_valid;
    logic [DATA_W-1:0] i_in_data;
    logic              o_in_ready;
    logic [3:0]        o_bank_cen;
    logic [3:0]        o_bank_wen;
    logic [ADDR_W-1:0] o_bank_addr;
    logic [DATA_W-1:0] o_bank_d;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_start, i_in_valid, i_in_data,
        input  o_in_ready, o_bank_cen, o_bank_wen, o_bank_addr, o_bank_d,
               o_busy, o_done
    );

    modport slave (
        input  i_start, i_in_valid, i_in_data,
        output o_in_ready, o_bank_cen, o_bank_wen, o_bank_addr, o_bank_d,
               o_busy, o_done
    );
endinterface

// File: rtl/img_load_ctrl.sv
// ---------------------------------------------------------------------------
// img_load_ctrl
// Upstream loader for the image-processing core. Accepts a 2048-byte image
// (8x8 pixels x 32 channels, raster order x, y, then channel) on a
// valid/ready byte stream and scatters it into four 512x8 single-port SRAM
// banks interleaved by column, so later stages can read a 4-column window in
// one cycle. A one-cycle done pulse hands the banks back to the core.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      img_load_ctrl_if.slave: start / byte stream in, bank write
//            bus, busy and done out
// ---------------------------------------------------------------------------
module img_load_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 9,
    parameter int N_BYTES = 2048
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    img_load_ctrl_if.slave  bus
);

    localparam int         N_W    = $clog2(N_BYTES);
    localparam logic [N_W-1:0] LAST_N = N_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N_W-1:0]    r_n;
    logic [3:0]        r_cen;
    logic [3:0]        r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_d;
    logic              w_accept;
    logic              w_last;
    logic              w_start;

    assign w_accept = (r_state == S_LOAD) && bus.i_in_valid;
    assign w_last   = w_accept && (r_n == LAST_N);
    assign w_start  = (r_state == S_IDLE) && bus.i_start;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. FLUSH exists so the write of the final byte is on
    // the bus while busy is still high; DONE is the single-cycle pulse.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_next = S_LOAD;
            S_LOAD:  if (w_last)      w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Byte index. Wraps to zero after the final accept, which leaves it
    // already cleared for the next load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n <= '0;
        end else if (w_start) begin
            r_n <= '0;
        end else if (w_accept) begin
            r_n <= r_n + 1'b1;
        end
    end

    // Registered write stage. Bank is x[1:0] = n[1:0]; address packs
    // {c, y, x[2]} = {n[10:6], n[5:3], n[2]}. Address and data hold when idle
    // so the bus only toggles on real writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cen  <= 4'hF;
            r_wen  <= 4'hF;
            r_addr <= '0;
            r_d    <= '0;
        end else if (w_accept) begin
            r_cen  <= ~(4'b0001 << r_n[1:0]);
            r_wen  <= ~(4'b0001 << r_n[1:0]);
            r_addr <= {r_n[10:6], r_n[5:3], r_n[2]};
            r_d    <= bus.i_in_data;
        end else begin
            r_cen  <= 4'hF;
            r_wen  <= 4'hF;
        end
    end

    assign bus.o_in_ready  = (r_state == S_LOAD);
    assign bus.o_busy      = (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign bus.o_done      = (r_state == S_DONE);
    assign bus.o_bank_cen  = r_cen;
    assign bus.o_bank_wen  = r_wen;
    assign bus.o_bank_addr = r_addr;
    assign bus.o_bank_d    = r_d;

endmodule

// File: tb/tb_img_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_img_load_ctrl
// Self-checking bench for img_load_ctrl. A negedge monitor records every
// bank write, models the four SRAM banks, and checks each write against the
// raster-order mapping computed arithmetically from the byte index.
// ---------------------------------------------------------------------------
module tb_img_load_ctrl;

    localparam int N = 2048;

    logic clk;
    logic rst_n;

    img_load_ctrl_if bus ();

    img_load_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Image currently being streamed, and the modelled bank contents.
    logic [7:0] img [N];
    logic [7:0] bankMem [4][512];

    // Monitor-owned running totals; the bench snapshots bases per load.
    int         logBank [N];
    int         logAddr [N];
    logic [7:0] logD    [N];
    int wrTotal = 0, seqErrTotal = 0, anomTotal = 0, doneTotal = 0;
    int bankTotal [4] = '{0, 0, 0, 0};
    int cyc = 0, doneCyc = -1, startCyc = -1, lastAcceptCyc = -1;
    bit prevAccept = 1'b0;

    // Bench-owned per-load baselines.
    int baseWr, baseSeq, baseAnom, baseDone;
    int baseBank [4];

    typedef struct {
        int         idx;
        int         bank;
        int         addr;
        logic [7:0] d;
    } vec_t;

    vec_t vecs [7];

    function automatic int expBank(input int idx);
        return idx % 4;
    endfunction

    function automatic int expAddr(input int idx);
        int c, y, x;
        c = idx / 64;
        y = (idx / 8) % 8;
        x = idx % 8;
        return c * 16 + y * 2 + x / 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin : monitor
        int  b;
        int  idx;
        bit  wrNow;
        cyc++;
        if (!rst_n) begin
            prevAccept = 1'b0;
        end else begin
            wrNow = (bus.o_bank_cen != 4'hF);
            if (wrNow != prevAccept) anomTotal++;
            if (bus.o_bank_cen != bus.o_bank_wen) anomTotal++;
            if (wrNow) begin
                if ($countones(~bus.o_bank_cen) != 1) anomTotal++;
                b = 0;
                for (int i = 0; i < 4; i++) if (!bus.o_bank_cen[i]) b = i;
                idx = wrTotal - baseWr;
                if (idx < N) begin
                    logBank[idx] = b;
                    logAddr[idx] = int'(bus.o_bank_addr);
                    logD[idx]    = bus.o_bank_d;
                    if (b != expBank(idx) || int'(bus.o_bank_addr) != expAddr(idx)
                        || bus.o_bank_d !== img[idx])
                        seqErrTotal++;
                end else begin
                    seqErrTotal++;
                end
                bankMem[b][bus.o_bank_addr] = bus.o_bank_d;
                bankTotal[b]++;
                wrTotal++;
            end
            if (bus.o_done) begin
                doneTotal++;
                doneCyc = cyc;
            end
            if (bus.i_start && !bus.o_busy && !bus.o_done) startCyc = cyc;
            prevAccept = bus.i_in_valid && bus.o_in_ready;
            if (prevAccept) lastAcceptCyc = cyc;
        end
    end

    task automatic beginLoad();
        baseWr   = wrTotal;
        baseSeq  = seqErrTotal;
        baseAnom = anomTotal;
        baseDone = doneTotal;
        for (int i = 0; i < 4; i++) baseBank[i] = bankTotal[i];
    endtask

    // Streams img[] as one load. Called at posedge+1.
    task automatic applyStimulus(input int maxGap, input int startPulseAt,
                                 input bit idleJunk, input int abortAt,
                                 input bit startInDone);
        int gap;
        int guard;
        beginLoad();
        if (idleJunk) begin
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = 8'hAA;
            repeat (4) @(posedge clk);
            #1;
            checkOutput("idleNoWrite", wrTotal - baseWr, 0);
            checkOutput("idleReady", bus.o_in_ready, 1'b0);
        end
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        checkOutput("readyAfterStart", bus.o_in_ready, 1'b1);
        checkOutput("busyAfterStart", bus.o_busy, 1'b1);
        for (int idx = 0; idx < N; idx++) begin
            if (idx == abortAt) begin
                bus.i_in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                checkOutput("abortCen", bus.o_bank_cen, 4'hF);
                checkOutput("abortWen", bus.o_bank_wen, 4'hF);
                checkOutput("abortBusy", bus.o_busy, 1'b0);
                checkOutput("abortReady", bus.o_in_ready, 1'b0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("abortWrites", wrTotal - baseWr, abortAt - 1);
                return;
            end
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            if (gap > 0) begin
                bus.i_in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = img[idx];
            bus.i_start    = (idx == startPulseAt);
            guard = 0;
            @(negedge clk);
            while (!bus.o_in_ready && guard < 8) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.o_in_ready) begin
                checkOutput("readyTimeout", bus.o_in_ready, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
        end
        bus.i_in_valid = 1'b0;
        guard = 0;
        while (!bus.o_done && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("doneSeen", bus.o_done, 1'b1);
        if (startInDone) begin
            bus.i_start = 1'b1;
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            checkOutput("startInDoneReady", bus.o_in_ready, 1'b0);
            checkOutput("startInDoneBusy", bus.o_busy, 1'b0);
            @(posedge clk);
            #1;
            checkOutput("startInDoneIdle", bus.o_in_ready, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic checkLoad(input string tag, input bit gapless);
        int mism;
        checkOutput({tag, ".writes"}, wrTotal - baseWr, N);
        for (int b = 0; b < 4; b++)
            checkOutput($sformatf("%s.bank%0dWrites", tag, b), bankTotal[b] - baseBank[b], 512);
        checkOutput({tag, ".doneCount"}, doneTotal - baseDone, 1);
        checkOutput({tag, ".seqErr"}, seqErrTotal - baseSeq, 0);
        checkOutput({tag, ".anomalies"}, anomTotal - baseAnom, 0);
        checkOutput({tag, ".doneLag"}, doneCyc - lastAcceptCyc, 2);
        if (gapless) checkOutput({tag, ".startToDone"}, doneCyc - startCyc + 1, 2051);
        mism = 0;
        for (int i = 0; i < N; i++)
            if (bankMem[expBank(i)][expAddr(i)] !== img[i]) mism++;
        checkOutput({tag, ".memMismatch"}, mism, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far",
                 passes, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{0,    0, 0,   8'd0};
        vecs[1] = '{5,    1, 1,   8'd5};
        vecs[2] = '{9,    1, 2,   8'd9};
        vecs[3] = '{68,   0, 17,  8'd68};
        vecs[4] = '{100,  0, 25,  8'd100};
        vecs[5] = '{1234, 2, 308, 8'd210};
        vecs[6] = '{2047, 3, 511, 8'd255};

        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_in_valid = 1'b0;
        bus.i_in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.ready", bus.o_in_ready, 1'b0);
        checkOutput("rst.cen", bus.o_bank_cen, 4'hF);
        checkOutput("rst.wen", bus.o_bank_wen, 4'hF);
        checkOutput("rst.addr", bus.o_bank_addr, 0);
        checkOutput("rst.d", bus.o_bank_d, 0);
        checkOutput("rst.busy", bus.o_busy, 1'b0);
        checkOutput("rst.done", bus.o_done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full gap-free load with data = n[7:0], junk valid in IDLE, and a
        // start attempt during the done pulse.
        for (int i = 0; i < N; i++) img[i] = 8'(i);
        applyStimulus(0, -1, 1'b1, -1, 1'b1);
        checkLoad("full", 1'b1);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("vec%0d.bank", vecs[i].idx), logBank[vecs[i].idx], vecs[i].bank);
            checkOutput($sformatf("vec%0d.addr", vecs[i].idx), logAddr[vecs[i].idx], vecs[i].addr);
            checkOutput($sformatf("vec%0d.d", vecs[i].idx), logD[vecs[i].idx], vecs[i].d);
        end

        // Same image with random valid gaps of 0-3 cycles.
        applyStimulus(3, -1, 1'b0, -1, 1'b0);
        checkLoad("gaps", 1'b0);

        // Stray start pulse mid-load.
        applyStimulus(0, 300, 1'b0, -1, 1'b0);
        checkLoad("startPulse", 1'b1);

        // Reset at n=1000, then a fresh load from index 0.
        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        applyStimulus(0, -1, 1'b0, 1000, 1'b0);
        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        applyStimulus(0, -1, 1'b0, -1, 1'b0);
        checkLoad("afterAbort", 1'b1);
        checkOutput("afterAbort.firstBank", logBank[0], 0);
        checkOutput("afterAbort.firstAddr", logAddr[0], 0);

        // Two back-to-back loads with different random images.
        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        applyStimulus(0, -1, 1'b0, -1, 1'b0);
        checkLoad("b2b1", 1'b1);
        for (int i = 0; i < N; i++) img[i] = ~img[i] ^ 8'($urandom_range(0, 15));
        applyStimulus(0, -1, 1'b0, -1, 1'b0);
        checkLoad("b2b2", 1'b1);
        checkOutput("b2b2.bank3addr511", bankMem[3][511], img[2047]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
